// File: rtl/md_unit.sv
// md_unit -- multiply/divide unit for the EX stage of the 5-stage MIPS pipeline.
//
// Runs MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency and owns the HI/LO
// registers, which MTHI/MTLO write directly.
//
// Handshake: busy is the inverse of "ready". An op on md_op is accepted only on
// a rising edge where busy==0. Any op presented while busy==1 is dropped, not
// queued. The hazard unit is responsible for holding MD-class ops back while
// busy is high. A multiply/divide result becomes visible on HI/LO in the cycle
// in which busy falls.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-low reset
//   md_op      in   3   0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 NOP
//   A          in   32  rs operand, sampled only at the start edge
//   B          in   32  rt operand, sampled only at the start edge
//   busy       out  1   operation in progress (registered)
//   HI         out  32  HI register
//   LO         out  32  LO register
//   dbg_state  out  2   FSM state: 0 IDLE, 1 MUL, 2 DIV
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  localparam logic [4:0] MUL_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        pending_q, pending_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;

  // Multiply: a single 64x64 multiplier on extended operands. Sign-extend for
  // MULT and zero-extend for MULTU. The low 64 bits are then the exact product
  // in either case.
  logic        mul_signed;
  logic [63:0] mul_a_ext, mul_b_ext, mul_res;

  assign mul_signed = (md_op == 3'd1);
  assign mul_a_ext  = {{32{mul_signed & A[31]}}, A};
  assign mul_b_ext  = {{32{mul_signed & B[31]}}, B};
  assign mul_res    = mul_a_ext * mul_b_ext;

  // Divide: an unsigned divide on magnitudes, followed by a sign fix-up.
  // The quotient is negative when the operand signs differ, which truncates
  // toward zero. The remainder follows the dividend. 0x80000000 / -1 falls out
  // naturally as 0x80000000 rem 0. The divisor is forced to 1 when B==0 only to
  // keep the divider defined; that result is discarded.
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  assign div_signed = (md_op == 3'd3);
  assign a_neg      = div_signed & A[31];
  assign b_neg      = div_signed & B[31];
  assign a_mag      = a_neg ? (32'd0 - A) : A;
  assign b_mag      = b_neg ? (32'd0 - B) : B;
  assign b_safe     = (B == 32'd0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quo        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    pending_d = pending_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    phi_d     = phi_q;
    plo_d     = plo_q;
    case (state_q)
      ST_IDLE: begin
        case (md_op)
          3'd1, 3'd2: begin
            {phi_d, plo_d} = mul_res;
            cnt_d          = MUL_LOAD;
            busy_d         = 1'b1;
            pending_d      = 1'b1;
            state_d        = ST_MUL;
          end
          3'd3, 3'd4: begin
            plo_d     = quo;
            phi_d     = rem;
            cnt_d     = DIV_LOAD;
            busy_d    = 1'b1;
            // A divide by zero runs the full latency but never writes HI/LO.
            pending_d = (B != 32'd0);
            state_d   = ST_DIV;
          end
          3'd5:    hi_d = A;
          3'd6:    lo_d = A;
          default: ;
        endcase
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == 5'd0) begin
          if (pending_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
          pending_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        busy_d    = 1'b0;
        pending_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 5'd0;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      phi_q     <= 32'd0;
      plo_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      phi_q     <= phi_d;
      plo_q     <= plo_d;
    end
  end

  assign busy      = busy_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [1:0]  dbg_state;

  md_unit #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .md_op    (md_op),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .HI       (HI),
    .LO       (LO),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];   // expected {HI,LO} after each multiply/divide
  int          len_q[$];   // expected busy length in cycles
  logic [31:0] hi_m, lo_m; // reference architectural HI/LO
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] cur_hi,
                                         input logic [31:0] cur_lo);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = {cur_hi, cur_lo};
    case (op)
      3'd1: begin sp = sa * sb; res = sp; end
      3'd2: begin up = ua * ub; res = up; end
      3'd3: if (b != 32'd0) begin
        sq = sa / sb;
        sr = sa % sb;
        res = {sr[31:0], sq[31:0]};
      end
      3'd4: if (b != 32'd0) begin
        up  = ua / ub;
        res = {32'(ua % ub), up[31:0]};
      end
      default: ;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    case ($urandom_range(0, 7))
      0:       w = 32'd0;
      1:       w = 32'hFFFF_FFFF;
      2:       w = 32'h8000_0000;
      3:       w = 32'($urandom_range(0, 20));
      default: w = $urandom;
    endcase
    return w;
  endfunction

  // ---------------- monitor ----------------
  int          run_len = 0;
  logic [31:0] prev_hi, prev_lo;
  logic [63:0] got_e;
  int          got_l;

  always @(negedge clk) begin
    if (!reset) begin
      run_len = 0;
    end else if (busy) begin
      if (run_len > 0) check("hilo_stable_while_busy", {HI, LO}, {prev_hi, prev_lo});
      run_len++;
    end else if (run_len > 0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_completion", 64'(run_len), 64'd0);
      end else begin
        got_e = exp_q.pop_front();
        got_l = len_q.pop_front();
        check("completion_hilo", {HI, LO}, got_e);
        check("busy_length", 64'(run_len), 64'(got_l));
      end
      run_len = 0;
    end
    prev_hi = HI;
    prev_lo = LO;
  end

  // ---------------- driver tasks ----------------
  // Present op for one cycle; after this returns the start edge has passed and
  // the operand buses are scrambled to prove they are not re-sampled.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    md_op = op;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    md_op = 3'd0;
    A     = $urandom;
    B     = $urandom;
  endtask

  task automatic push_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    e = ref_md(op, a, b, hi_m, lo_m);
    exp_q.push_back(e);
    len_q.push_back((op == 3'd1 || op == 3'd2) ? MULT_CYCLES : DIV_CYCLES);
    {hi_m, lo_m} = e;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) check("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    push_md(op, a, b);
    start_op(op, a, b);
    wait_idle();
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] a);
    @(posedge clk);
    #1;
    md_op = op;
    A     = a;
    B     = $urandom;
    #1;
    // Same cycle as the write: the old value is still presented.
    check("mt_no_bypass", {HI, LO}, {hi_m, lo_m});
    if (op == 3'd5) hi_m = a;
    else            lo_m = a;
    @(posedge clk);
    #1;
    md_op = 3'd0;
    check("mt_result", {HI, LO}, {hi_m, lo_m});
    check("mt_busy", 64'(busy), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    reset = 1'b0;
    md_op = 3'd0;
    A     = 32'd0;
    B     = 32'd0;
    hi_m  = 32'd0;
    lo_m  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    reset = 1'b1;

    // Directed cases
    run_md(3'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult_neg2x3", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    run_md(3'd3, 32'hFFFF_FFF9, 32'd2);
    check("div_neg7_2", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md(3'd4, 32'd7, 32'd2);
    check("divu_7_2", {HI, LO}, 64'h0000_0001_0000_0003);
    do_mt(3'd5, 32'h1234);
    run_md(3'd4, 32'd99, 32'd0);
    check("divu_by_zero", {HI, LO}, {32'h1234, 32'h3});
    run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_overflow", {HI, LO}, 64'h0000_0000_8000_0000);

    // MTLO while busy is ignored
    push_md(3'd1, 32'd1000, 32'hFFFF_FFFD);
    start_op(3'd1, 32'd1000, 32'hFFFF_FFFD);
    md_op = 3'd6;
    A     = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    md_op = 3'd0;
    check("busy_during_ignored_mtlo", 64'(busy), 64'd1);
    wait_idle();
    check("mtlo_ignored", {32'd0, LO}, {32'd0, lo_m});

    // Async reset in the middle of a multiply
    push_md(3'd1, 32'd12345, 32'd6789);
    start_op(3'd1, 32'd12345, 32'd6789);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_hilo", {HI, LO}, 64'd0);
    exp_q.delete();
    len_q.delete();
    hi_m = 32'd0;
    lo_m = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    do_mt(3'd6, 32'd5);
    check("mtlo_after_reset", {32'd0, LO}, 64'd5);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = rand_word();
      b  = rand_word();
      case (op)
        3'd1, 3'd2, 3'd3, 3'd4: run_md(op, a, b);
        3'd5, 3'd6:             do_mt(op, a);
        default: begin
          start_op(op, a, b);
          check("nop_hilo", {HI, LO}, {hi_m, lo_m});
          check("nop_busy", 64'(busy), 64'd0);
        end
      endcase
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
